// File: rtl/fix_rx_parser.sv
// fix_rx_parser: parses inbound FIX "tag=value<SOH>" bytes into tag/value events and verifies the CheckSum field
module fix_rx_parser #(
  parameter int TAG_W = 16,
  parameter logic [7:0] SOH = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             new_message_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_i,
  output logic [TAG_W-1:0] tag_o,
  output logic             tag_valid_o,
  output logic [7:0]       value_o,
  output logic             value_valid_o,
  output logic             field_end_o,
  output logic             msg_end_o,
  output logic             checksum_ok_o,
  output logic             abort_o,
  output logic             err_o,
  output logic [2:0]       err_code_o
);
  typedef enum logic [2:0] {IDLE, TAG, VALUE, CKSUM, DONE, ERR} state_t;
  state_t state, st;
  logic [TAG_W-1:0] tag_acc, acc;
  logic [TAG_W+3:0] prod;
  logic [7:0] sum, fsum, s, fs;
  logic [9:0] ck, c;
  logic [2:0] nck, n, ec;
  logic [3:0] d;
  logic has_dig, hd, started, is_dig, ovf, take;
  // st/acc/s/... are the state as seen by this byte: new_message_i restarts the message first
  always_comb begin
    st = new_message_i ? TAG : state;
    acc = new_message_i ? '0 : tag_acc;
    hd = ~new_message_i & has_dig;
    s = new_message_i ? '0 : sum;
    fs = new_message_i ? '0 : fsum;
    c = new_message_i ? '0 : ck;
    n = new_message_i ? '0 : nck;
    is_dig = byte_i >= 8'h30 && byte_i <= 8'h39;
    d = byte_i[3:0];
    prod = {4'b0, acc} * (TAG_W+4)'(10) + (TAG_W+4)'(d);
    ovf = |prod[TAG_W+3:TAG_W];
    take = byte_valid_i && (st == TAG || st == VALUE || st == CKSUM);
    ec = !take ? 3'd0
       : st == TAG ? (is_dig ? (ovf ? 3'd3 : 3'd0) : byte_i == 8'h3d ? (hd ? 3'd0 : 3'd2) : byte_i == SOH ? 3'd4 : 3'd1)
       : st == CKSUM ? (is_dig ? (n == 3'd3 ? 3'd5 : 3'd0) : (byte_i != SOH || n != 3'd3) ? 3'd5 : c != {2'b0, fs} ? 3'd6 : 3'd0)
       : 3'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tag_acc <= '0;
      has_dig <= 1'b0;
      started <= 1'b0;
      sum <= '0;
      fsum <= '0;
      ck <= '0;
      nck <= '0;
      tag_o <= '0;
      tag_valid_o <= 1'b0;
      value_o <= '0;
      value_valid_o <= 1'b0;
      field_end_o <= 1'b0;
      msg_end_o <= 1'b0;
      checksum_ok_o <= 1'b0;
      abort_o <= 1'b0;
      err_o <= 1'b0;
      err_code_o <= '0;
    end else begin
      tag_valid_o <= 1'b0;
      value_valid_o <= 1'b0;
      field_end_o <= 1'b0;
      msg_end_o <= 1'b0;
      abort_o <= 1'b0;
      err_o <= 1'b0;
      if (new_message_i) begin
        abort_o <= (state == TAG && started) || state == VALUE || state == CKSUM;
        state <= TAG;
        tag_acc <= '0;
        has_dig <= 1'b0;
        started <= 1'b0;
        sum <= '0;
        fsum <= '0;
        ck <= '0;
        nck <= '0;
        err_code_o <= '0;
        checksum_ok_o <= 1'b0;
      end
      if (take) begin
        sum <= s + byte_i;
        started <= 1'b1;
        if (ec != 3'd0 && ec != 3'd6) begin
          err_o <= 1'b1;
          err_code_o <= ec;
          state <= ERR;
        end else if (st == TAG) begin
          if (is_dig) begin
            tag_acc <= prod[TAG_W-1:0];
            has_dig <= 1'b1;
          end else begin
            tag_valid_o <= 1'b1;
            tag_o <= acc;
            state <= acc == TAG_W'(10) ? CKSUM : VALUE;
          end
        end else if (st == VALUE) begin
          if (byte_i == SOH) begin
            field_end_o <= 1'b1;
            tag_acc <= '0;
            has_dig <= 1'b0;
            fsum <= s + byte_i;
            state <= TAG;
          end else begin
            value_valid_o <= 1'b1;
            value_o <= byte_i;
          end
        end else if (is_dig) begin
          value_valid_o <= 1'b1;
          value_o <= byte_i;
          ck <= c * 10'd10 + {6'b0, d};
          nck <= n + 3'd1;
        end else begin
          field_end_o <= 1'b1;
          msg_end_o <= 1'b1;
          checksum_ok_o <= ec == 3'd0;
          err_o <= ec != 3'd0;
          err_code_o <= ec;
          state <= DONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_fix_rx_parser.sv
// tb_fix_rx_parser: random and directed FIX messages checked against a field-level reference model
module tb_fix_rx_parser;
  typedef logic [7:0] bq_t[$];
  logic clk = 0, rst = 1, nm = 0, bv = 0;
  logic [7:0] b = 0;
  logic [15:0] tag;
  logic [7:0] val;
  logic tv, vv, fe, me, ok, ab, er;
  logic [2:0] ec;
  int n_cmp = 0, n_bad = 0;
  bq_t msg;
  int got_tags[$], got_vals[$], exp_tags[$], exp_vals[$];
  int got_fe, got_me, got_ok, got_err, got_ab;
  int exp_fe, exp_me, exp_ok, exp_ec, exp_open, last_open = 0;
  logic [7:0] pk[4] = '{8'h01, 8'h61, 8'h3d, 8'h37};
  always #5 clk = ~clk;
  fix_rx_parser dut (
    .clk(clk), .rst(rst), .new_message_i(nm), .byte_valid_i(bv), .byte_i(b),
    .tag_o(tag), .tag_valid_o(tv), .value_o(val), .value_valid_o(vv),
    .field_end_o(fe), .msg_end_o(me), .checksum_ok_o(ok), .abort_o(ab),
    .err_o(er), .err_code_o(ec)
  );
  always @(negedge clk) if (!rst) begin
    if (tv) got_tags.push_back(int'(tag));
    if (vv) got_vals.push_back(int'(val));
    if (fe) got_fe++;
    if (me) begin got_me++; got_ok = int'(ok); end
    if (er) got_err++;
    if (ab) got_ab++;
  end
  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  function automatic void add(input string s);
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i] == "|" ? 8'h01 : 8'(s[i]));
  endfunction
  function automatic int msum();
    int s = 0;
    foreach (msg[j]) s += int'(msg[j]);
    return s % 256;
  endfunction
  function automatic void add_ck(input int bias);
    add($sformatf("10=%03d|", (msum() + bias) % 256));
  endfunction
  function automatic bit isdig(input logic [7:0] x);
    return x >= 8'h30 && x <= 8'h39;
  endfunction
  function automatic void model(input bq_t m);
    int i = 0, t, nd, k, v, fs;
    exp_tags.delete(); exp_vals.delete();
    exp_fe = 0; exp_me = 0; exp_ok = 0; exp_ec = 0; exp_open = 1;
    while (i < m.size()) begin
      fs = 0;
      for (int j = 0; j < i; j++) fs += int'(m[j]);
      fs %= 256;
      t = 0; nd = 0;
      while (i < m.size() && isdig(m[i])) begin
        t = t * 10 + int'(m[i]) - 48;
        if (t > 65535) begin exp_ec = 3; exp_open = 0; return; end
        i++; nd++;
      end
      if (i == m.size()) return;
      if (m[i] != 8'h3d) begin exp_ec = m[i] == 8'h01 ? 4 : 1; exp_open = 0; return; end
      if (nd == 0) begin exp_ec = 2; exp_open = 0; return; end
      exp_tags.push_back(t);
      i++;
      if (t == 10) begin
        k = 0; v = 0;
        while (i < m.size() && isdig(m[i]) && k < 3) begin
          v = v * 10 + int'(m[i]) - 48;
          exp_vals.push_back(int'(m[i]));
          k++; i++;
        end
        if (i == m.size()) return;
        exp_open = 0;
        if (m[i] == 8'h01 && k == 3) begin
          exp_fe++; exp_me = 1; exp_ok = int'(v == fs); exp_ec = exp_ok ? 0 : 6;
        end else exp_ec = 5;
        return;
      end
      while (i < m.size() && m[i] != 8'h01) begin exp_vals.push_back(int'(m[i])); i++; end
      if (i == m.size()) return;
      exp_fe++;
      i++;
    end
  endfunction
  task automatic run_msg(input bit sep);
    int ab_exp = last_open;
    model(msg);
    @(negedge clk);
    got_tags.delete(); got_vals.delete();
    got_fe = 0; got_me = 0; got_ok = 0; got_err = 0; got_ab = 0;
    nm = 1; bv = 0;
    if (sep) begin @(negedge clk); nm = 0; end
    foreach (msg[j]) begin
      bv = 1; b = msg[j];
      @(negedge clk);
      nm = 0; bv = 0;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("tag_cnt", got_tags.size(), exp_tags.size());
    foreach (exp_tags[k]) if (k < got_tags.size()) check("tag", got_tags[k], exp_tags[k]);
    check("val_cnt", got_vals.size(), exp_vals.size());
    foreach (exp_vals[k]) if (k < got_vals.size()) check("val", got_vals[k], exp_vals[k]);
    check("field_end", got_fe, exp_fe);
    check("msg_end", got_me, exp_me);
    check("ck_ok_pulse", got_ok, exp_ok);
    check("ck_ok_held", int'(ok), exp_ok);
    check("err_cnt", got_err, int'(exp_ec != 0));
    check("err_code", int'(ec), exp_ec);
    check("abort", got_ab, ab_exp);
    last_open = exp_open;
  endtask
  initial begin
    int t;
    logic [7:0] cc;
    repeat (3) @(negedge clk);
    check("rst_tag", int'(tag), 0);
    check("rst_outs", int'({val, tv, vv, fe, me, ok, ab, er, ec}), 0);
    rst = 0;
    msg.delete(); add("5=X|");
    foreach (msg[j]) begin @(negedge clk); bv = 1; b = msg[j]; end
    @(negedge clk); bv = 0;
    repeat (2) @(negedge clk);
    check("pre_msg_ignored", got_tags.size() + got_vals.size() + got_fe + got_err, 0);
    msg.delete(); add("35=A|10=231|"); run_msg(0);
    @(negedge clk); nm = 1; bv = 1; b = 8'h35;
    @(negedge clk); nm = 0; b = 8'h3d;
    check("lat_abort", int'(ab), 0);
    check("lat_tv_early", int'(tv), 0);
    @(negedge clk); bv = 0;
    check("lat_tv", int'(tv), 1);
    check("lat_tag", int'(tag), 5);
    @(negedge clk);
    check("lat_tv_pulse", int'(tv), 0);
    last_open = 1;
    msg.delete(); add("35=A|10=232|"); run_msg(1);
    msg.delete(); add("3a=X|"); run_msg(0);
    msg.delete(); add("70000=1|"); run_msg(0);
    msg.delete(); add("58=|"); add_ck(0); run_msg(0);
    msg.delete(); add("9=x|10=23|"); run_msg(0);
    msg.delete(); add("=5|"); run_msg(1);
    msg.delete(); add("7=a|10=1234|"); run_msg(0);
    msg.delete(); add("49=AB"); run_msg(0);
    msg.delete(); add("56=Z|"); run_msg(0);
    msg.delete(); add("49=AB"); run_msg(0);
    rst = 1;
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_outs", int'({tag, tv, vv, fe, me, ok, ab, er, ec}), 0);
    end
    rst = 0;
    last_open = 0;
    msg.delete(); add("8=F|"); run_msg(0);
    repeat (300) begin
      msg.delete();
      repeat ($urandom_range(0, 4)) begin
        t = $urandom_range(0, 9) == 0 ? $urandom_range(60000, 99999) : $urandom_range(11, 999);
        add($sformatf("%0d=", t));
        repeat ($urandom_range(0, 5)) begin
          cc = 8'($urandom_range(32, 126));
          msg.push_back(cc == 8'h7c ? 8'h7e : cc);
        end
        msg.push_back(8'h01);
      end
      add_ck($urandom_range(0, 4) == 0 ? 1 : 0);
      if ($urandom_range(0, 3) == 0) msg[$urandom_range(0, msg.size() - 1)] = pk[$urandom_range(0, 3)];
      run_msg(1'($urandom_range(0, 1)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
